sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/ksa_adder32.sv | 36 +++
 rtl/sha256_sigma_small.sv | 21 ++
 rtl/sha256_msg_sched.sv | 146 ++++++++++++++
 tb/tb_sha256_msg_sched.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message schedule: word width,
// scheduler FSM states and the rotate/shift amounts of the small sigmas.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

endpackage

// File: rtl/ksa_adder32.sv
// 32-bit Kogge-Stone adder: parallel-prefix generate/propagate tree with
// carry-in folded in after the prefix network.
module ksa_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  // Level 0 is the per-bit generate/propagate; level 5 spans all lower bits.
  logic [5:0][31:0] g;
  logic [5:0][31:0] p;
  logic [32:0]      c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < 5; l++) begin : g_lvl
    for (genvar i = 0; i < 32; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign c[0]    = c_in;
  assign c[32:1] = g[5] | (p[5] & {32{c_in}});
  assign sum     = p[0] ^ c[31:0];
  assign c_out   = c[32];

endmodule

// File: rtl/sha256_sigma_small.sv
// Small SHA-256 sigma function: two right-rotates and one logical right
// shift XORed together; the amounts select sigma0 or sigma1.
module sha256_sigma_small
  import sha256_pkg::*;
#(
  parameter int ROT_A = S0_ROT_A,
  parameter int ROT_B = S0_ROT_B,
  parameter int SHR   = S0_SHR
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  logic [WORD_W-1:0] rot_a;
  logic [WORD_W-1:0] rot_b;

  assign rot_a = (x >> ROT_A) | (x << (WORD_W - ROT_A));
  assign rot_b = (x >> ROT_B) | (x << (WORD_W - ROT_B));
  assign y     = rot_a ^ rot_b ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator. Loads M0..M15 through a 16-word
// shift window, then expands W16..W63, emitting one word per cycle
// through a single registered output slot.
//
// Handshakes: a word moves on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that edge; ready
// may change freely and never depends on valid from the same side.
module sha256_msg_sched #(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              busy,
  output logic              done
);
  import sha256_pkg::*;

  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
  localparam logic [5:0] LOAD_LAST = 6'd15;

  state_t state_q, state_d;

  // win_q[15] is W[t-1] ... win_q[0] is W[t-16] for the next word t.
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] out_data_q;
  logic [5:0]        out_idx_q;
  logic [5:0]        next_idx_q;
  logic              out_valid_q;
  logic              done_q;

  logic slot_free;
  logic in_fire;
  logic last_held;
  logic gen_fire;
  logic last_fire;
  logic start_take;

  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;
  logic [WORD_W-1:0] sum_a;
  logic [WORD_W-1:0] sum_b;
  logic [WORD_W-1:0] w_new;
  logic              carry_unused_a;
  logic              carry_unused_b;
  logic              carry_unused_c;

  // Output slot can take a new word if empty or being drained this cycle.
  assign slot_free  = !out_valid_q || out_ready;
  assign in_fire    = (state_q == LOAD) && slot_free && in_valid;
  assign last_held  = out_valid_q && (out_idx_q == LAST_IDX);
  assign gen_fire   = (state_q == EXPAND) && slot_free && !last_held;
  assign last_fire  = (state_q == EXPAND) && last_held && out_ready;
  // done_q high means the block just ended; a start then is not honoured.
  assign start_take = (state_q == IDLE) && start && !done_q;

  sha256_sigma_small #(
    .ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR)
  ) u_sigma0 (
    .x(win_q[1]),
    .y(sig0)
  );

  sha256_sigma_small #(
    .ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR)
  ) u_sigma1 (
    .x(win_q[14]),
    .y(sig1)
  );

  // Two-level adder tree: (sigma1 + W[t-7]) + (sigma0 + W[t-16]).
  ksa_adder32 u_add_a (
    .a(sig1), .b(win_q[9]), .c_in(1'b0), .sum(sum_a), .c_out(carry_unused_a)
  );

  ksa_adder32 u_add_b (
    .a(sig0), .b(win_q[0]), .c_in(1'b0), .sum(sum_b), .c_out(carry_unused_b)
  );

  ksa_adder32 u_add_c (
    .a(sum_a), .b(sum_b), .c_in(1'b0), .sum(w_new), .c_out(carry_unused_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_take) state_d = LOAD;
      LOAD:    if (in_fire && (next_idx_q == LOAD_LAST)) state_d = EXPAND;
      EXPAND:  if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window, output slot, index counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      next_idx_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_fire;
      if (start_take) begin
        next_idx_q <= '0;
      end
      if (in_fire || gen_fire) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15]   <= in_fire ? in_data : w_new;
        out_data_q  <= in_fire ? in_data : w_new;
        out_idx_q   <= next_idx_q;
        out_valid_q <= 1'b1;
        next_idx_q  <= next_idx_q + 6'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == LOAD) && slot_free;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: a reference schedule model fills an
// expected queue per block; a negedge monitor pops and compares every
// accepted word and watches stall stability and the done pulse.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int blocks_expected = 0;
  bit bp_mode = 1'b0;

  logic [37:0] exp_q[$];
  logic [31:0] msg [16];
  logic [31:0] cap [64];

  sha256_msg_sched #(.ROUNDS(64), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_done"},      {63'd0, done},      64'd0);
    check({tag, "_out_data"},  {32'd0, out_data},  64'd0);
    check({tag, "_out_idx"},   {58'd0, out_idx},   64'd0);
  endtask

  // reference model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic push_expected();
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        w[t] = msg[t];
      end else begin
        s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      exp_q.push_back({6'(t), w[t]});
    end
    blocks_expected++;
  endtask

  // drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_block();
    for (int i = 0; i < 64; i++) cap[i] = '0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_words(input bit bubbles);
    int  n;
    bit  got;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!got) begin
        checks++;
        errors++;
        $error("FAIL in_accept_timeout word=%0d observed=no_accept expected=accept", i);
      end
      in_valid = 1'b0;
      if (bubbles) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_count < blocks_expected && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("block_done", {63'd0, done_count >= blocks_expected}, 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idx(input logic [5:0] idx, input bit need_accept);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      @(negedge clk);
      hit = out_valid && (out_idx == idx) && (!need_accept || out_ready);
      n++;
    end
    check("wait_idx_seen", {63'd0, hit}, 64'd1);
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic check_abc_words(input string tag);
    check({tag, "_w16"}, {32'd0, cap[16]}, 64'h61626380);
    check({tag, "_w17"}, {32'd0, cap[17]}, 64'h000F0000);
    check({tag, "_w63"}, {32'd0, cap[63]}, 64'h12B1EDEB);
  endtask

  // scoreboard monitor
  bit          prev_stall = 1'b0;
  bit          prev_last = 1'b0;
  logic [31:0] held_data = '0;
  logic [5:0]  held_idx = '0;

  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {25'd0, out_valid, out_idx, out_data},
              {25'd0, 1'b1, held_idx, held_data});
      end
      check("done_pulse", {63'd0, done}, {63'd0, prev_last});
      if (prev_last) begin
        check("busy_after_done", {63'd0, busy}, 64'd0);
        done_count++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_idx   = out_idx;
      prev_last  = 1'b0;
      if (out_valid && out_ready) begin
        cap[out_idx] = out_data;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_word observed=idx%0d:%0h expected=none", out_idx, out_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sched_word", {26'd0, out_idx, out_data}, {26'd0, e});
        end
        if (out_idx == 6'd63) prev_last = 1'b1;
      end
    end
  end

  // directed sequence
  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // abc block, continuous flow
    load_abc();
    push_expected();
    start_block();
    feed_words(1'b0);
    wait_done();
    check_abc_words("abc");

    // same block under random output backpressure
    bp_mode = 1'b1;
    push_expected();
    start_block();
    feed_words(1'b0);
    wait_done();
    check_abc_words("abc_bp");
    bp_mode = 1'b0;

    // input bubbles every other cycle
    push_expected();
    start_block();
    feed_words(1'b1);
    wait_done();
    check_abc_words("abc_bubble");

    // reset in the middle of expansion, then a fresh block
    push_expected();
    start_block();
    feed_words(1'b0);
    wait_idx(6'd30, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    blocks_expected--;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    push_expected();
    start_block();
    feed_words(1'b0);
    wait_done();
    check_abc_words("abc_after_rst");

    // start pulses during EXPAND and coincident with done
    push_expected();
    start_block();
    feed_words(1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    check("expand_busy", {63'd0, busy}, 64'd1);
    check("expand_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idx(6'd63, 1'b1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_on_done_busy", {63'd0, busy}, 64'd0);
    check("start_on_done_in_ready", {63'd0, in_ready}, 64'd0);
    wait_done();
    check_abc_words("abc_ign_start");

    // all-ones block with backpressure and bubbles: carries wrap
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
    bp_mode = 1'b1;
    push_expected();
    start_block();
    feed_words(1'b1);
    wait_done();
    bp_mode = 1'b0;

    // random message block
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    push_expected();
    start_block();
    feed_words(1'b0);
    wait_done();

    repeat (2) @(negedge clk);
    check("idle_busy_end", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
